// File: rtl/vga_pkg.sv
// Shared VGA constants and types used by the draw engines and the pixel-port
// arbiter that feeds vga_adapter.
package vga_pkg;

  // Pixel field widths at the adapter interface.
  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int C_W = 3;

  // Visible screen area; coordinates at or beyond these are off-screen.
  localparam int XMAX = 320;
  localparam int YMAX = 240;

  // Width of a requester index (supports up to 8 requesters).
  localparam int IDX_W = 3;

  // 3-bit RGB colour constants shared by the draw engines.
  localparam logic [C_W-1:0] BLACK   = 3'b000;
  localparam logic [C_W-1:0] BLUE    = 3'b001;
  localparam logic [C_W-1:0] GREEN   = 3'b010;
  localparam logic [C_W-1:0] CYAN    = 3'b011;
  localparam logic [C_W-1:0] RED     = 3'b100;
  localparam logic [C_W-1:0] MAGENTA = 3'b101;
  localparam logic [C_W-1:0] YELLOW  = 3'b110;
  localparam logic [C_W-1:0] WHITE   = 3'b111;

  // Ownership state of the shared pixel port.
  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_t;

endpackage : vga_pkg

// File: rtl/plot_arbiter_rr_pick.sv
// Combinational round-robin selector: grants the first requesting, unmasked
// index found scanning last+1, last+2, ... modulo NREQ. Output is one-hot or 0.
module rr_pick
  import vga_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  mask,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  gnt
);

  logic [NREQ-1:0]   eligible;
  logic [NREQ-1:0]   rotated;
  logic [NREQ-1:0]   rotated_low;
  logic [2*NREQ-1:0] doubled;
  logic [2*NREQ-1:0] restored;
  logic [IDX_W:0]    shamt;

  // Rotate so that index last+1 sits at bit 0, isolate the lowest set bit,
  // then rotate back. Doubling the vector makes the modulo wrap free.
  always_comb begin
    eligible    = req & mask;
    shamt       = {1'b0, last} + (IDX_W+1)'(1);
    doubled     = {eligible, eligible} >> shamt;
    rotated     = doubled[NREQ-1:0];
    rotated_low = rotated & (-rotated);
    restored    = {rotated_low, rotated_low} << shamt;
    gnt         = restored[2*NREQ-1:NREQ];
  end

endmodule : rr_pick

// File: rtl/plot_arbiter.sv
// Shares the single VGA adapter pixel-write port between NREQ draw engines.
// One pixel per cycle, round-robin, with an optional lock so a requester can
// draw a whole sprite atomically. Off-screen pixels are accepted but clipped.
module plot_arbiter
  import vga_pkg::*;
#(
  parameter int NREQ         = 3,
  parameter int XMAX         = vga_pkg::XMAX,
  parameter int YMAX         = vga_pkg::YMAX,
  parameter int LOCK_TIMEOUT = 15
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     lock,
  input  logic [X_W*NREQ-1:0] x_in,
  input  logic [Y_W*NREQ-1:0] y_in,
  input  logic [C_W*NREQ-1:0] c_in,
  output logic [NREQ-1:0]     gnt,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [C_W-1:0]      c_out,
  output logic                plot,
  output logic [IDX_W-1:0]    owner,
  output logic                locked
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [X_W:0] X_LIMIT = (X_W+1)'(XMAX);
  localparam logic [Y_W:0] Y_LIMIT = (Y_W+1)'(YMAX);

  // One-hot to index; a zero vector maps to 0.
  function automatic logic [IDX_W-1:0] oh_to_idx(input logic [NREQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  lock_state_t      state_q, state_d;
  logic [NREQ-1:0]  owner_oh_q, owner_oh_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0]  pick;
  logic [NREQ-1:0]  mask;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] owner_idx;
  logic             accept;
  logic             lock_acc;
  logic             req_owner;
  logic [X_W-1:0]   x_sel;
  logic [Y_W-1:0]   y_sel;
  logic [C_W-1:0]   c_sel;
  logic             on_screen;

  // While locked only the owner may win; otherwise everyone is eligible.
  assign mask = (state_q == ST_LOCKED) ? owner_oh_q : '1;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req  (req),
    .mask (mask),
    .last (last_q),
    .gnt  (pick)
  );

  // Grant is suppressed while reset is held so no pixel is accepted then.
  assign gnt       = resetn ? pick : '0;
  assign accept    = |gnt;
  assign lock_acc  = |(lock & gnt);
  assign req_owner = |(req & owner_oh_q);
  assign gnt_idx   = oh_to_idx(gnt);
  assign owner_idx = oh_to_idx(owner_oh_q);
  assign owner     = owner_idx;
  assign locked    = (state_q == ST_LOCKED);

  // Select the granted requester's pixel fields with an AND-OR mux.
  // NOTE: every combinational output gets a default before any branch or loop,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    x_sel = '0;
    y_sel = '0;
    c_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      x_sel |= x_in[i*X_W +: X_W] & {X_W{gnt[i]}};
      y_sel |= y_in[i*Y_W +: Y_W] & {Y_W{gnt[i]}};
      c_sel |= c_in[i*C_W +: C_W] & {C_W{gnt[i]}};
    end
    on_screen = ({1'b0, x_sel} < X_LIMIT) && ({1'b0, y_sel} < Y_LIMIT);
  end

  // Lock FSM next state, round-robin pointer update and stall timeout.
  always_comb begin
    state_d    = state_q;
    owner_oh_d = owner_oh_q;
    last_d     = last_q;
    cnt_d      = cnt_q;

    if (accept) last_d = gnt_idx;

    unique case (state_q)
      ST_UNLOCKED: begin
        if (accept && lock_acc) begin
          state_d    = ST_LOCKED;
          owner_oh_d = gnt;
          cnt_d      = '0;
        end
      end
      ST_LOCKED: begin
        if (accept) begin
          // Only the owner can be granted here; any accepted pixel restarts
          // the stall window, and one without lock ends the burst.
          cnt_d = '0;
          if (!lock_acc) state_d = ST_UNLOCKED;
        end else if (!req_owner) begin
          if (cnt_q >= TIMEOUT_LAST) begin
            state_d = ST_UNLOCKED;
            cnt_d   = '0;
            last_d  = owner_idx;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_UNLOCKED;
        cnt_d   = '0;
      end
    endcase
  end

  // State, pointer and counter registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= ST_UNLOCKED;
      owner_oh_q <= '0;
      last_q     <= IDX_W'(NREQ - 1);
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_oh_q <= owner_oh_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
    end
  end

  // Registered adapter-side pixel; fields hold when nothing is accepted.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      x_out <= '0;
      y_out <= '0;
      c_out <= '0;
      plot  <= 1'b0;
    end else if (accept) begin
      x_out <= x_sel;
      y_out <= y_sel;
      c_out <= c_sel;
      plot  <= on_screen;
    end else begin
      plot  <= 1'b0;
    end
  end

endmodule : plot_arbiter

// File: doc/plot_arbiter.md
Name: plot_arbiter

Overview:
- Shares the single pixel-write port of the VGA adapter (x 9b, y 8b, colour 3b, plot) between NREQ independent drawing engines, e.g. terrain/lava scroller, player sprite, eraser and overlay.
- Round-robin arbitration is done one pixel per cycle.
- A requester can lock the port so a whole sprite draws atomically.
- Off-screen pixels are clipped, and the adapter-side outputs are registered.
- Sits between the game-logic draw engines and vga_adapter in the top level.

Parameters:
- NREQ, 3, number of requesters (2..8).
- XMAX, 320, horizontal resolution; x >= XMAX is clipped.
- YMAX, 240, vertical resolution; y >= YMAX is clipped.
- LOCK_TIMEOUT, 15, idle cycles before a stalled lock is forcibly released (>= 1).

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  synchronous, active-low reset.
- req  in  NREQ  per-requester pixel valid.
- lock  in  NREQ  per-requester "keep ownership after this pixel".
- x_in  in  9*NREQ  flattened x coords; requester i at [9i+8:9i].
- y_in  in  8*NREQ  flattened y coords; requester i at [8i+7:8i].
- c_in  in  3*NREQ  flattened colours; requester i at [3i+2:3i].
- gnt  out  NREQ  one-hot grant, combinational, same cycle as req.
- x_out  out  9  registered x to adapter.
- y_out  out  8  registered y to adapter.
- c_out  out  3  registered colour to adapter.
- plot  out  1  registered write strobe to adapter.
- owner  out  3  index of the locked owner; valid only while locked=1.
- locked  out  1  lock currently held.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - x_out=0, y_out=0, c_out=0, plot=0.
  - locked=0, owner=0.
  - RR pointer last=NREQ-1, so requester 0 has first priority.
  - Timeout counter = 0.
  - gnt=0 while resetn=0.
- Transfer:
  - A pixel from requester i is accepted in a cycle where req[i]=1 and gnt[i]=1.
  - At most one gnt bit is high per cycle; gnt[i] is never high when req[i]=0.
- Unlocked arbitration:
  - Grant the first requesting index scanning last+1, last+2, ... modulo NREQ.
  - On acceptance, last <= granted index.
  - With no requests, gnt=0 and last is unchanged.
- Output latency is 1 cycle. On the edge after acceptance:
  - x_out/y_out/c_out are loaded with the granted fields.
  - plot=1 iff x<XMAX and y<YMAX. A clipped pixel is still accepted (gnt=1) but gives plot=0.
  - With no acceptance, plot=0 and x/y/c hold their last values.
- Lock FSM, states UNLOCKED and LOCKED:
  - UNLOCKED -> LOCKED when an accepted pixel has lock[i]=1; owner<=i.
  - In LOCKED, only the owner can be granted, and it is granted whenever req[owner]=1. Other requests stall and are not reordered.
  - LOCKED -> UNLOCKED when the owner completes an accepted pixel with lock[owner]=0. That pixel is output normally, and last<=owner.
  - Timeout: in LOCKED, the counter increments each cycle with req[owner]=0 and clears on any owner acceptance.
  - When the counter reaches LOCK_TIMEOUT, the block returns to UNLOCKED on that edge and the counter clears. Arbitration resumes next cycle from last=owner.
  - Deasserting lock without req has no effect; release requires an accepted pixel or the timeout.
- Simultaneous events:
  - Release and a new lock by a different requester cannot occur in the same cycle, because only the owner is granted.
  - An owner pixel with lock=1 keeps LOCKED.
- Reset mid-lock or mid-burst: everything returns to reset state next edge, and the in-flight registered pixel is dropped (plot=0).
- Widths: x_in and y_in are compared unsigned against XMAX and YMAX. The counter is $clog2(LOCK_TIMEOUT+1) bits and saturates; it never wraps.

Decomposition:
- Shared package (vga_pkg) holds:
  - X_W=9, Y_W=8, C_W=3.
  - Screen constants XMAX=320, YMAX=240.
  - Colour constants (BLACK=3'b000, RED=3'b100, WHITE=3'b111, ...) reused by the draw engines.
- One natural sub-module, rr_pick: a combinational round-robin selector taking req, mask and last, returning a one-hot grant. The lock FSM, timeout counter and output register stay in plot_arbiter.

Test Plan:
- Reset check: hold resetn=0 for 2 cycles with req=3'b111 -> gnt=0, plot=0, x_out=0, locked=0. On release, the first grant goes to requester 0.
- Round-robin: req=3'b111 held for 6 cycles, no lock -> gnt sequence 001,010,100,001,010,100. plot=1 every cycle from cycle 2, with x_out matching each requester's x one cycle later.
- Atomic sprite: req1 sends 4 pixels with lock=1,1,1,0 while req0 and req2 are held high -> gnt=010 for 4 consecutive cycles, locked=1 with owner=1 through the 3rd pixel, locked=0 after the 4th. The next grant goes to requester 2.
- Clipping: requester 0 sends (319,239), (320,10), (5,240) -> gnt high for all three; plot=1,0,0. x_out=320 is still registered on the 2nd pixel.
- Lock timeout: requester 2 accepts a pixel with lock=1, then drops req while req0=1 -> gnt0 stays 0 for 15 cycles. locked falls on the 15th idle edge and gnt0=1 the following cycle.
- Reset mid-lock: owner=1 locked, assert resetn=0 for one cycle -> locked=0, plot=0, last=2 next cycle. With req=3'b011, requester 0 is granted first.
